// File: rtl/blob_pkg.sv
// Shared types, default dimensions and the per-pixel hit test for the blob tracker.
package blob_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int         DEF_IMG_W      = 320;
  localparam int         DEF_IMG_H      = 240;
  localparam int         DEF_MIN_PIXELS = 64;
  localparam logic [3:0] DEF_THRESH     = 4'd8;

  // A pixel counts when any 4-bit channel reaches the threshold.
  function automatic logic is_hit(input logic [11:0] pix, input logic [3:0] thr);
    return (pix[11:8] >= thr) || (pix[7:4] >= thr) || (pix[3:0] >= thr);
  endfunction

endpackage

// File: rtl/color_blob_tracker_raster_counter.sv
// Raster position tracker: presents the coordinate of the pixel being accepted
// this cycle (forced to (0,0) on start) and advances it when a pixel is taken.
module raster_counter
  import blob_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Current coordinate; a frame start overrides whatever was left over.
  always_comb begin
    x    = start ? '0 : x_q;
    y    = start ? '0 : y_q;
    last = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
  end

  // Advance past the accepted pixel, wrapping at line and frame ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step) begin
      if (x == XW'(IMG_W - 1)) begin
        x_q <= '0;
        y_q <= last ? '0 : y + 1'b1;
      end else begin
        x_q <= x + 1'b1;
        y_q <= y;
      end
    end
  end

endmodule

// File: rtl/color_blob_tracker.sv
// Per-frame colour blob tracker: counts threshold hits and their bounding box,
// then reports the totals one cycle after the last pixel of each frame.
module color_blob_tracker
  import blob_pkg::*;
#(
  parameter int         IMG_W      = DEF_IMG_W,
  parameter int         IMG_H      = DEF_IMG_H,
  parameter logic [3:0] THRESH     = DEF_THRESH,
  parameter int         MIN_PIXELS = DEF_MIN_PIXELS,
  localparam int CW = $clog2(IMG_W * IMG_H + 1),
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   pixel_in,
  input  logic          in_ready,
  input  logic          sof,
  output logic [CW-1:0] hit_count,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic          detected,
  output logic          result_valid
);

  localparam logic [CW-1:0] MIN_C = CW'(MIN_PIXELS);

  state_t        state_q, state_d;
  logic          start, take, hit, last;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [CW-1:0] acc_cnt;
  logic [XW-1:0] acc_xmin, acc_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax;

  // A qualified sof always begins a new frame, whatever the state.
  assign start = in_ready & sof;
  assign hit   = take & is_hit(pixel_in, THRESH);

  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_raster (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .step (take),
    .x    (cx),
    .y    (cy),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and pixel acceptance; outside ACCUM only a frame start is taken.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        take = start;
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        take = in_ready;
        if (in_ready && last) state_d = REPORT;
      end
      REPORT: begin
        take    = start;
        state_d = start ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Running hit count and bounding box; a frame start discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= '0;
      acc_xmin <= '0;
      acc_xmax <= '0;
      acc_ymin <= '0;
      acc_ymax <= '0;
    end else if (start) begin
      acc_cnt  <= {{(CW-1){1'b0}}, hit};
      acc_xmin <= cx;
      acc_xmax <= cx;
      acc_ymin <= cy;
      acc_ymax <= cy;
    end else if (hit) begin
      acc_cnt <= acc_cnt + 1'b1;
      if (acc_cnt == '0) begin
        acc_xmin <= cx;
        acc_xmax <= cx;
        acc_ymin <= cy;
        acc_ymax <= cy;
      end else begin
        if (cx < acc_xmin) acc_xmin <= cx;
        if (cx > acc_xmax) acc_xmax <= cx;
        if (cy < acc_ymin) acc_ymin <= cy;
        if (cy > acc_ymax) acc_ymax <= cy;
      end
    end
  end

  // Latch results during the REPORT cycle; the box reads zero when nothing was detected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count    <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      detected     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_q == REPORT);
      if (state_q == REPORT) begin
        hit_count <= acc_cnt;
        if (acc_cnt >= MIN_C) begin
          detected <= 1'b1;
          x_min    <= acc_xmin;
          x_max    <= acc_xmax;
          y_min    <= acc_ymin;
          y_max    <= acc_ymax;
        end else begin
          detected <= 1'b0;
          x_min    <= '0;
          x_max    <= '0;
          y_min    <= '0;
          y_max    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Directed bench for color_blob_tracker on an 8x4 image with a frame-level
// reference model feeding a result scoreboard.
module tb_color_blob_tracker;

  localparam int W = 8, H = 4, N = W * H, MINP = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic [11:0] pixel_in = '0;
  logic        in_ready = 1'b0, sof = 1'b0;
  logic [5:0]  hit_count;
  logic [2:0]  x_min, x_max;
  logic [1:0]  y_min, y_max;
  logic        detected, result_valid;

  typedef struct packed {
    logic [5:0] cnt;
    logic [2:0] xmn, xmx;
    logic [1:0] ymn, ymx;
    logic       det;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0, miscompares = 0, pushed = 0, seen = 0;
  logic [11:0] f[N];

  color_blob_tracker #(.IMG_W(W), .IMG_H(H), .THRESH(4'd8), .MIN_PIXELS(MINP)) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .in_ready    (in_ready),
    .sof         (sof),
    .hit_count   (hit_count),
    .x_min       (x_min),
    .x_max       (x_max),
    .y_min       (y_min),
    .y_max       (y_max),
    .detected    (detected),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: scans the whole frame buffer.
  function automatic exp_t model();
    exp_t e;
    int cnt = 0, xmn = 0, xmx = 0, ymn = 0, ymx = 0;
    for (int i = 0; i < N; i++) begin
      logic [11:0] p;
      p = f[i];
      if (p[11:8] >= 4'd8 || p[7:4] >= 4'd8 || p[3:0] >= 4'd8) begin
        if (cnt == 0) begin
          xmn = i % W; xmx = i % W; ymn = i / W; ymx = i / W;
        end else begin
          if (i % W < xmn) xmn = i % W;
          if (i % W > xmx) xmx = i % W;
          if (i / W < ymn) ymn = i / W;
          if (i / W > ymx) ymx = i / W;
        end
        cnt++;
      end
    end
    e.cnt = 6'(cnt);
    e.det = (cnt >= MINP);
    e.xmn = e.det ? 3'(xmn) : 3'd0;
    e.xmx = e.det ? 3'(xmx) : 3'd0;
    e.ymn = e.det ? 2'(ymn) : 2'd0;
    e.ymx = e.det ? 2'(ymx) : 2'd0;
    return e;
  endfunction

  // Scoreboard: every result pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst && result_valid) begin
      exp_t e;
      seen++;
      check("rv_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("hit_count", 32'(hit_count), 32'(e.cnt));
        check("x_min",     32'(x_min),     32'(e.xmn));
        check("x_max",     32'(x_max),     32'(e.xmx));
        check("y_min",     32'(y_min),     32'(e.ymn));
        check("y_max",     32'(y_max),     32'(e.ymx));
        check("detected",  32'(detected),  32'(e.det));
      end
    end
  end

  task automatic clr_frame();
    for (int i = 0; i < N; i++) f[i] = 12'h000;
  endtask

  task automatic setp(input int x, input int y, input logic [11:0] v);
    f[y * W + x] = v;
  endtask

  task automatic push_exp();
    sb.push_back(model());
    pushed++;
  endtask

  task automatic drive(input logic [11:0] p, input logic s);
    @(negedge clk);
    pixel_in = p;
    sof      = s;
    in_ready = 1'b1;
  endtask

  // Idle cycles carry junk pixels and an unqualified sof that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_ready = 1'b0;
      sof      = 1'($urandom_range(1));
      pixel_in = 12'($urandom);
    end
  endtask

  task automatic run_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(1) == 1) idle(1);
      drive(f[i], i == 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt"},  32'(hit_count), 32'd0);
    check({tag, "_xmin"}, 32'(x_min), 32'd0);
    check({tag, "_xmax"}, 32'(x_max), 32'd0);
    check({tag, "_ymin"}, 32'(y_min), 32'd0);
    check({tag, "_ymax"}, 32'(y_max), 32'd0);
    check({tag, "_det"},  32'(detected), 32'd0);
    check({tag, "_rv"},   32'(result_valid), 32'd0);
  endtask

  initial begin
    idle(3);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Hits before any sof are ignored, then an empty frame.
    repeat (5) drive(12'hFFF, 1'b0);
    idle(2);
    check("no_rv_before_sof", 32'(seen), 32'd0);
    clr_frame();
    push_exp();
    run_frame(N, 1'b0);
    idle(4);
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Three hits spread over the frame.
    clr_frame();
    setp(2, 1, 12'hF00); setp(5, 3, 12'hF00); setp(3, 2, 12'hF00);
    push_exp();
    run_frame(N, 1'b0);
    idle(4);
    check("drain_three", 32'(sb.size()), 32'd0);

    // Single hit at end of first line; sub-threshold pixels are not hits.
    clr_frame();
    setp(7, 0, 12'h080); setp(0, 0, 12'h007); setp(3, 3, 12'h777);
    push_exp();
    run_frame(N, 1'b0);
    idle(4);
    check("drain_single", 32'(sb.size()), 32'd0);

    // Early restart at pixel 10 discards the partial frame.
    clr_frame();
    setp(1, 0, 12'hF00); setp(4, 0, 12'h0F0); setp(6, 0, 12'h00F);
    run_frame(10, 1'b0);
    clr_frame();
    setp(6, 1, 12'h0F0); setp(0, 3, 12'h00F);
    push_exp();
    run_frame(N, 1'b0);
    idle(4);
    check("drain_restart", 32'(sb.size()), 32'd0);

    // Random in_ready gaps must not change the result.
    clr_frame();
    setp(2, 1, 12'hF00); setp(5, 3, 12'hF00); setp(3, 2, 12'hF00);
    push_exp();
    run_frame(N, 1'b1);
    idle(4);
    check("drain_gaps", 32'(sb.size()), 32'd0);

    // Reset mid-frame clears outputs and drops the partial frame.
    clr_frame();
    for (int i = 0; i < 12; i++) f[i] = 12'h888;
    run_frame(12, 1'b0);
    @(negedge clk);
    in_ready = 1'b0;
    rst      = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) drive(12'hFFF, 1'b0);
    idle(2);
    check("no_rv_after_rst", 32'(seen), 32'(pushed));
    clr_frame();
    setp(0, 0, 12'hF00); setp(7, 3, 12'h00F);
    push_exp();
    run_frame(N, 1'b0);
    idle(4);
    check("drain_corners", 32'(sb.size()), 32'd0);

    // Back-to-back frames: the second sof lands in the REPORT cycle.
    clr_frame();
    setp(7, 3, 12'hF00);
    push_exp();
    run_frame(N, 1'b0);
    clr_frame();
    setp(0, 0, 12'h0F0); setp(1, 1, 12'h0F0); setp(2, 2, 12'hF00);
    push_exp();
    run_frame(N, 1'b0);
    idle(4);
    check("drain_b2b", 32'(sb.size()), 32'd0);

    check("rv_total", 32'(seen), 32'(pushed));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/color_blob_tracker.md
COLOR_BLOB_TRACKER -- requirements
Module: color_blob_tracker

Interface
REQ-001 Parameter IMG_W, default 320, active pixels per line.
REQ-002 Parameter IMG_H, default 240, lines per frame.
REQ-003 Parameter THRESH, default 4'd8, minimum channel intensity for a pixel to count as a hit.
REQ-004 Parameter MIN_PIXELS, default 64, minimum hit count for a frame to report a detection.
REQ-005 clk  input  1  single clock; one clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 pixel_in  input  12  filtered RGB444 pixel {r[11:8],g[7:4],b[3:0]} from the colour-filter stage.
REQ-008 in_ready  input  1  pixel_in valid this cycle.
REQ-009 sof  input  1  start of frame; qualified by in_ready; marks pixel (0,0).
REQ-010 hit_count  output  CW  hits in last completed frame; CW = $clog2(IMG_W*IMG_H+1).
REQ-011 x_min, x_max  output  XW each  bounding-box columns; XW = $clog2(IMG_W).
REQ-012 y_min, y_max  output  YW each  bounding-box rows; YW = $clog2(IMG_H).
REQ-013 detected  output  1  last completed frame had hit_count >= MIN_PIXELS.
REQ-014 result_valid  output  1  one-cycle pulse when the outputs above update.

Function
REQ-015 Hit: in_ready=1 and any of r, g, b >= THRESH (unsigned 4-bit compare).
REQ-016 FSM states: IDLE, ACCUM, REPORT; reset state IDLE.
REQ-017 IDLE: pixels ignored; in_ready & sof -> ACCUM, with that pixel processed as (0,0) in the same cycle.
REQ-018 ACCUM: each in_ready advances x; at x=IMG_W-1, x wraps to 0 and y increments; in_ready=0 holds all counters.
REQ-019 ACCUM: a hit increments the internal count and updates running min/max of x and y; the first hit of a frame loads min=max=current coordinate.
REQ-020 ACCUM: in_ready at (IMG_W-1, IMG_H-1) processes that pixel, then -> REPORT.
REQ-021 ACCUM: in_ready & sof (early frame restart) discards the partial frame, clears the accumulators, treats the pixel as (0,0) of the new frame, and stays in ACCUM; no result_valid is issued.
REQ-022 REPORT: lasts exactly one cycle; latches the outputs and asserts result_valid; next state IDLE, or ACCUM if in_ready & sof in that cycle (that pixel is processed as (0,0)).
REQ-023 Latency: result_valid is asserted on the clock edge after the last-pixel edge, i.e. visible one cycle after the last pixel is sampled.
REQ-024 If count < MIN_PIXELS at REPORT: detected=0, the box outputs are 0, and hit_count still carries the true count.
REQ-025 Outputs hold their values between reports.
REQ-026 count never wraps; its maximum is IMG_W*IMG_H, which fits in CW bits.

Reset
REQ-027 rst low asynchronously forces IDLE and clears x, y, count, running box, all outputs and result_valid to 0.
REQ-028 Reset mid-frame discards the partial frame; after release the block waits for the next sof.

Structure
REQ-029 Package blob_pkg holds the state enum typedef (IDLE/ACCUM/REPORT) and default dimension constants.
REQ-030 One sub-module, raster_counter, provides the x/y counters with wrap, sof clear and a last-pixel flag; the hit test, min/max tracking and FSM stay in color_blob_tracker.

Verification (bench uses IMG_W=8, IMG_H=4, THRESH=8, MIN_PIXELS=2)
REQ-031 Full frame, all pixels 12'h000 -> result_valid once, hit_count=0, detected=0, box all 0.
REQ-032 Hits 12'hF00 at (2,1), (5,3), (3,2), all others 0 -> hit_count=3, x_min=2, x_max=5, y_min=1, y_max=3, detected=1.
REQ-033 Single hit 12'h0080 at (7,0) -> hit_count=1, detected=0, box 0; 12'h007 (below THRESH) is not a hit.
REQ-034 sof re-asserted at pixel 10, then a full frame with 2 hits -> exactly one result_valid, hit_count=2.
REQ-035 in_ready gaps (random 50% duty) across a frame -> same result as back-to-back input; rst pulsed low mid-frame -> all outputs 0, no result_valid until the next full frame.
REQ-036 Pixels before the first sof -> ignored; sof asserted in the REPORT cycle -> the next frame is accumulated correctly.
